elevator_timer: RTL and testbench

Parametrised multi-channel timer for the elevator controller. One shared prescaler generates a tick every TICK_DIV clocks, and a free-running seconds counter advances on each tick. CH independent down-counting channels time door-open, travel and idle timeouts. Each channel runs one-shot or periodic, supports start, restart and stop, and issues a single-cycle expire pulse that the controller FSM consumes.

---
 rtl/elevator_timer.sv | 123 ++++++++++++
 tb/tb_elevator_timer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/elevator_timer.sv
// Multi-channel timer for the elevator controller: a shared tick prescaler,
// a free-running seconds counter, and CH independent down-counting channels
// with one-shot or auto-reload behaviour and a single-cycle expire pulse.
module elevator_timer #(
  parameter int TICK_DIV = 2,
  parameter int CNT_W    = 4,
  parameter int CH       = 2
) (
  input  logic                  clk,
  input  logic                  reseta,
  input  logic [CH-1:0]         start,
  input  logic [CH-1:0]         stop,
  input  logic [CH-1:0]         periodic,
  input  logic [CH*CNT_W-1:0]   load_val,
  output logic                  tick,
  output logic [CNT_W-1:0]      sec,
  output logic [CH*CNT_W-1:0]   count,
  output logic [CH-1:0]         busy,
  output logic [CH-1:0]         expire
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  logic [PW-1:0]    p_q, p_d;
  logic [CNT_W-1:0] sec_q, sec_d;

  // Tick is a pure decode of the prescaler register; with TICK_DIV=1 the
  // prescaler sits at 0 == P_LAST, so tick is constantly high.
  assign tick = (p_q == P_LAST);
  assign sec  = sec_q;

  // Prescaler wraps at TICK_DIV-1; seconds counter advances on each tick.
  always_comb begin
    p_d   = (p_q == P_LAST) ? '0 : p_q + PW'(1);
    sec_d = tick ? sec_q + CNT_W'(1) : sec_q;
  end

  // Shared prescaler and seconds registers.
  always_ff @(posedge clk) begin
    if (reseta) begin
      p_q   <= '0;
      sec_q <= '0;
    end else begin
      p_q   <= p_d;
      sec_q <= sec_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] count_q, count_d;
      logic [CNT_W-1:0] rl_q, rl_d;
      logic [CNT_W-1:0] ld;
      logic             md_q, md_d;
      logic             exp_q, exp_d;

      assign ld = load_val[gi*CNT_W +: CNT_W];

      // Channel next state: start beats stop beats tick; a zero load
      // expires immediately and leaves the channel idle.
      always_comb begin
        state_d = state_q;
        count_d = count_q;
        rl_d    = rl_q;
        md_d    = md_q;
        exp_d   = 1'b0;
        if (start[gi]) begin
          count_d = ld;
          rl_d    = ld;
          md_d    = periodic[gi];
          if (ld != '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
            exp_d   = 1'b1;
          end
        end else if (stop[gi]) begin
          state_d = S_IDLE;
        end else if (tick && state_q == S_RUN) begin
          if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
          end else begin
            // Terminal count: reload in periodic mode, otherwise park at 0.
            exp_d = 1'b1;
            if (md_q) begin
              count_d = rl_q;
            end else begin
              count_d = '0;
              state_d = S_IDLE;
            end
          end
        end
      end

      // Channel state registers; reset clears everything, including expire.
      always_ff @(posedge clk) begin
        if (reseta) begin
          state_q <= S_IDLE;
          count_q <= '0;
          rl_q    <= '0;
          md_q    <= 1'b0;
          exp_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          count_q <= count_d;
          rl_q    <= rl_d;
          md_q    <= md_d;
          exp_q   <= exp_d;
        end
      end

      assign count[gi*CNT_W +: CNT_W] = count_q;
      assign busy[gi]                 = (state_q == S_RUN);
      assign expire[gi]               = exp_q;
    end
  endgenerate

endmodule

// File: tb/tb_elevator_timer.sv
// Directed bench for elevator_timer (TICK_DIV=2, CNT_W=4, CH=2). Expected
// values are queued before each clock edge and compared after it.
module tb_elevator_timer;

  logic       clk = 1'b0;
  logic       reseta = 1'b1;
  logic [1:0] start = '0;
  logic [1:0] stop = '0;
  logic [1:0] periodic = '0;
  logic [7:0] load_val = '0;
  logic       tick;
  logic [3:0] sec;
  logic [7:0] count;
  logic [1:0] busy;
  logic [1:0] expire;

  elevator_timer #(.TICK_DIV(2), .CNT_W(4), .CH(2)) dut (
    .clk(clk), .reseta(reseta), .start(start), .stop(stop),
    .periodic(periodic), .load_val(load_val), .tick(tick), .sec(sec),
    .count(count), .busy(busy), .expire(expire)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n = 0;  // edges since the last reset edge

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0:       return 32'(tick);
      1:       return 32'(sec);
      2:       return 32'(count[3:0]);
      3:       return 32'(count[7:4]);
      4:       return 32'(busy);
      default: return 32'(expire);
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sig = sig; x.exp = e;
    sb.push_back(x);
  endtask

  // Queue channel expectations, clock once, add prescaler expectations,
  // then drain the scoreboard against the DUT outputs.
  task automatic step(input logic [3:0] c0, input logic [3:0] c1,
                      input logic [1:0] bz, input logic [1:0] ex,
                      input string tag);
    exp_t x;
    logic [31:0] obs;
    push({tag, ".count0"}, 2, 32'(c0));
    push({tag, ".count1"}, 3, 32'(c1));
    push({tag, ".busy"}, 4, 32'(bz));
    push({tag, ".expire"}, 5, 32'(ex));
    @(posedge clk);
    #1;
    if (reseta) n = 0; else n++;
    push({tag, ".tick"}, 0, 32'(n % 2));
    push({tag, ".sec"}, 1, 32'((n / 2) % 16));
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = observe(x.sig);
      vectors++;
      assert (obs === x.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", x.tag, obs, x.exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset for one cycle, then idle through a full sec wrap
    reseta = 1'b1;
    step(0, 0, 2'b00, 2'b00, "reset");
    reseta = 1'b0;
    for (int i = 0; i < 32; i++) step(0, 0, 2'b00, 2'b00, "idle");

    // 2. one-shot ch0, load 3 (start on a non-tick edge)
    start = 2'b01; load_val = {4'd0, 4'd3}; periodic = 2'b00;
    step(3, 0, 2'b01, 2'b00, "os_start");
    start = 2'b00;
    step(2, 0, 2'b01, 2'b00, "os");
    step(2, 0, 2'b01, 2'b00, "os");
    step(1, 0, 2'b01, 2'b00, "os");
    step(1, 0, 2'b01, 2'b00, "os");
    step(0, 0, 2'b00, 2'b01, "os_expire");
    step(0, 0, 2'b00, 2'b00, "os_after");

    // 3. periodic ch1, load 2, started on a tick edge
    start = 2'b10; load_val = {4'd2, 4'd0}; periodic = 2'b10;
    step(0, 2, 2'b10, 2'b00, "per_start");
    start = 2'b00;
    for (int m = 1; m < 12; m++) begin
      step(0, ((m % 4) >= 2) ? 4'd1 : 4'd2, 2'b10,
           ((m % 4) == 0) ? 2'b10 : 2'b00, "per");
    end
    stop = 2'b10;  // lands on a tick edge with count=1: stop must win
    step(0, 1, 2'b00, 2'b00, "per_stop");
    stop = 2'b00;
    for (int i = 0; i < 6; i++) step(0, 1, 2'b00, 2'b00, "per_stopped");

    // 4. ch0 load 5, stop at 3, restart with 4
    start = 2'b01; load_val = {4'd0, 4'd5}; periodic = 2'b00;
    step(5, 1, 2'b01, 2'b00, "rs_start");
    start = 2'b00;
    step(4, 1, 2'b01, 2'b00, "rs");
    step(4, 1, 2'b01, 2'b00, "rs");
    step(3, 1, 2'b01, 2'b00, "rs");
    stop = 2'b01;
    step(3, 1, 2'b00, 2'b00, "rs_stop");
    stop = 2'b00;
    for (int i = 0; i < 4; i++) step(3, 1, 2'b00, 2'b00, "rs_hold");
    start = 2'b01; load_val = {4'd0, 4'd4};
    step(4, 1, 2'b01, 2'b00, "rs_restart");
    start = 2'b00;
    for (int m = 1; m < 12; m++) begin
      step((m >= 8) ? 4'd0 : 4'(4 - m / 2), 1,
           (m < 8) ? 2'b01 : 2'b00, (m == 8) ? 2'b01 : 2'b00, "rs_run");
    end

    // 5. edge cases: zero load, start+stop together on a tick edge
    start = 2'b01; load_val = {4'd0, 4'd0};
    step(0, 1, 2'b00, 2'b01, "zero_load");
    start = 2'b00;
    step(0, 1, 2'b00, 2'b00, "zero_after");
    start = 2'b10; stop = 2'b10; load_val = {4'd7, 4'd0}; periodic = 2'b00;
    step(0, 7, 2'b10, 2'b00, "start_stop_tick");
    start = 2'b00; stop = 2'b00;
    step(0, 7, 2'b10, 2'b00, "ss_after");

    // 6. reset while both channels run
    start = 2'b01; load_val = {4'd0, 4'd9}; periodic = 2'b01;
    step(9, 6, 2'b11, 2'b00, "both_run");
    start = 2'b00;
    reseta = 1'b1;
    step(0, 0, 2'b00, 2'b00, "rst_mid");
    reseta = 1'b0;
    step(0, 0, 2'b00, 2'b00, "rst_tick1");
    step(0, 0, 2'b00, 2'b00, "rst_tick2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
